// File: rtl/spi_slave.sv
// spi_slave: SPI target; oversamples sck/cs_n/mosi in clk domain, full-duplex words, buffered TX, RX strobe, frame status.
// Ports: clk, rst (async high); sck, cs_n, mosi in; miso, miso_oe out; tx_data/tx_load/tx_ready TX buffer handshake;
// rx_data/rx_valid RX word strobe; busy, frame_done frame status; underrun sticky (built only with SPI_SLAVE_UNDERRUN_EN).
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic POL = 1'(CPOL);
  localparam logic PHA = 1'(CPHA);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic lead, trail, smp, shf, cs_fall, cs_rise;
  logic [CW-1:0] cnt;
  logic done;
  logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh, tx_next;
  logic reload, shift_out, sample, complete;
  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign lead    = (sck_d == POL) && (sck_s != POL);
  assign trail   = (sck_d != POL) && (sck_s == POL);
  assign smp     = PHA ? trail : lead;
  assign shf     = PHA ? lead : trail;
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign busy    = state != IDLE;
  assign miso_oe = busy;
  assign tx_next = tx_ready ? '0 : tx_buf;
  // Mode 0/2 preload in LOAD; every word after the first (and CPHA=1 always) loads on the shift edge that opens it.
  assign reload    = !cs_rise && ((state == LOAD && !PHA) ||
                     (state == ACTIVE && shf && cnt == '0 && (PHA || done)));
  assign shift_out = !cs_rise && state == ACTIVE && shf && !reload;
  assign sample    = !cs_rise && state == ACTIVE && smp;
  assign complete  = !cs_rise && state == ACTIVE && cnt == CW'(DATA_W);
  always_comb begin
    state_d = cs_rise ? IDLE :
              (state == IDLE && cs_fall) ? LOAD :
              (state == LOAD) ? ACTIVE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync   <= {SYNC_STAGES{POL}};
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sck_d      <= POL;
      cs_d       <= 1'b1;
      cnt        <= '0;
      done       <= 1'b0;
      tx_buf     <= '0;
      tx_ready   <= 1'b1;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_done <= 1'b0;
      miso       <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d      <= sck_s;
      cs_d       <= cs_s;
      rx_valid   <= complete;
      frame_done <= cs_rise;
      if (cs_rise) begin
        cnt  <= '0;
        done <= 1'b0;
        miso <= 1'b0;
      end else begin
        if (sample) begin
          rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
          cnt   <= cnt + 1'b1;
        end
        if (complete) begin
          rx_data <= rx_sh;
          cnt     <= '0;
          done    <= 1'b1;
        end
        if (reload) begin
          tx_sh <= tx_next;
          miso  <= tx_next[DATA_W-1];
          done  <= 1'b0;
        end else if (shift_out) begin
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          miso  <= tx_sh[DATA_W-2];
        end
      end
      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (reload) tx_ready <= 1'b1;
    end
  end
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun_q <= 1'b0;
    else if (state == IDLE && cs_fall) underrun_q <= 1'b0;
    else if (reload && tx_ready) underrun_q <= 1'b1;
  end
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) end of the link driven by spi_master; the design uses it as the peripheral-side model and as a loopback partner in benches.
- Oversamples the external SCK/CS_N/MOSI in the system clock domain, shifts full-duplex words, and exposes a parallel RX strobe and a buffered TX load handshake.
- Carries frame status analogous to the master's start_status/start_clear: busy while selected, one-cycle pulse at frame end.

Parameters:
- DATA_W, 8, word width in bits; MSB first on the wire.
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on the leading edge, 1 = sample on the trailing edge.
- SYNC_STAGES, 2, synchronizer depth for sck, cs_n and mosi; minimum 2.

Ports:
- clk  in  1  system clock; SCK frequency must not exceed clk/8.
- rst  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from the master (asynchronous).
- cs_n  in  1  chip select, active low (asynchronous).
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  output enable for the miso pad; 1 while selected.
- tx_data  in  DATA_W  next word to transmit.
- tx_load  in  1  write strobe for tx_data; accepted when tx_ready=1.
- tx_ready  out  1  TX holding buffer empty.
- rx_data  out  DATA_W  last received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse when CS deasserts.
- underrun  out  1  sticky flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high, on rst): miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_done=0, underrun=0, FSM in IDLE, bit counter 0, all synchronizers cleared. cs_n synchronizers reset to 1; sck synchronizers reset to CPOL.
- Synchronization: each input passes through SYNC_STAGES flops, followed by one history flop for edge detection.
  - Leading edge = sck transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge is the other one.
- TX buffer: one word deep.
  - tx_load && tx_ready writes the buffer and clears tx_ready on the next cycle.
  - tx_load while tx_ready=0 is ignored; the buffer keeps its contents.
  - The buffer empties (tx_ready=1) on the cycle it is transferred into the shift register.
- FSM states: IDLE, LOAD, ACTIVE.
  - IDLE -> LOAD on synced cs_n falling edge. busy=1 and miso_oe=1 from this cycle.
  - LOAD (one cycle): for CPHA=0, transfer the TX buffer to the shift register (0 if the buffer is empty) and drive miso = shift MSB. For CPHA=1, the transfer happens at the first shift edge of each word instead. LOAD -> ACTIVE.
  - ACTIVE, on each sample edge: shift in mosi at the LSB and increment the bit counter.
  - When the counter reaches DATA_W: rx_data <= shifted word, rx_valid=1 for 1 cycle (the cycle after the synced edge is detected), counter <= 0.
  - ACTIVE, on each shift edge: if the counter is 0 and a word has completed (CPHA=0), or the counter is 0 (CPHA=1), reload from the TX buffer. Otherwise shift the output, miso = next bit.
  - Any state -> IDLE on synced cs_n rising edge: frame_done=1 for 1 cycle, busy=0, miso_oe=0, miso=0.
    - A partial word is discarded: no rx_valid, counter cleared.
    - The TX buffer is kept if it has not been loaded.
- Simultaneous events:
  - A word completion and tx_load in the same cycle are handled independently.
  - A cs_n rising edge has priority over a coincident sck edge.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the pin-level sample edge of the last bit.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined: underrun is set when a word transfer into the shift register finds the TX buffer empty (zeros are sent). It stays set until rst or until the next IDLE->LOAD transition.
- Undefined: underrun is tied to 0, no detection logic is built, and zeros are still sent on an empty buffer.

Test Plan:
- Mode 0, tx_load 0x3C before CS, master sends 0xA5 -> rx_data=0xA5, one rx_valid pulse; miso bits 0,0,1,1,1,1,0,0; tx_ready=1 after LOAD; frame_done pulse at CS high.
- Mode 0, two back-to-back words 0x12, 0x34; TX 0x55 then 0xAA loaded during word 1 -> rx_valid twice with 0x12 then 0x34; miso carries 0x55 then 0xAA; underrun=0.
- Mode 0, CS deasserted after 5 bits of 0xFF -> no rx_valid, rx_data holds its previous value, frame_done=1; the next full 0x81 frame receives correctly.
- With SPI_SLAVE_UNDERRUN_EN defined and no tx_load, send 0x7E -> miso all zeros, underrun=1, rx_data=0x7E; underrun clears at the next CS fall. Without the macro, underrun stays 0.
- Instance with CPOL=1, CPHA=1: tx 0xC3, rx 0x5A -> rx_data=0x5A; miso 0xC3 sampled by the master on rising edges.
- rst pulse mid-word (after 3 bits) -> all outputs return to reset values immediately; the next complete frame works normally.
